// File: rtl/bitblaster_pkg.sv
// Shared definitions for the BitBlaster multi-cycle controller.
//   - Bus, register-address and opcode widths.
//   - Instruction field positions.
//   - Opcode and timestep enums.
//   - ALU operation selects.
//   - The control bundle that the decoder produces.
package bitblaster_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 2;
  localparam int OPC_W  = 4;
  localparam int IMM_W  = 4;

  // Instruction layout: [9:6] opcode, [5:4] Rx, [3:2] Ry, [3:0] imm
  localparam int OPC_MSB = 9;
  localparam int RX_LSB  = 4;
  localparam int RY_LSB  = 2;

  typedef enum logic [OPC_W-1:0] {
    OP_LOAD = 4'b0000,
    OP_COPY = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_INV  = 4'b0100,
    OP_FLP  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_ADDI = 4'b1001,
    OP_SUBI = 4'b1010
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  localparam logic [OPC_W-1:0] ALU_NONE = 4'b0000;
  localparam logic [OPC_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OPC_W-1:0] ALU_SUB  = 4'b0011;
  localparam logic [OPC_W-1:0] ALU_INV  = 4'b0100;
  localparam logic [OPC_W-1:0] ALU_FLP  = 4'b0101;
  localparam logic [OPC_W-1:0] ALU_AND  = 4'b0110;
  localparam logic [OPC_W-1:0] ALU_OR   = 4'b0111;
  localparam logic [OPC_W-1:0] ALU_XOR  = 4'b1000;
  localparam logic [OPC_W-1:0] ALU_ADDI = 4'b1001;
  localparam logic [OPC_W-1:0] ALU_SUBI = 4'b1010;

  typedef struct packed {
    logic              extern_sel;
    logic              ain;
    logic              gin;
    logic              gout;
    logic              immout;
    logic              enw;
    logic              enr0;
    logic              enr1;
    logic              done;
    logic [ADDR_W-1:0] wra;
    logic [ADDR_W-1:0] rda0;
    logic [ADDR_W-1:0] rda1;
    logic [OPC_W-1:0]  alucont;
  } ctrl_t;

  // The ALU select code is the opcode of the arithmetic/logic instruction.
  function automatic logic [OPC_W-1:0] alu_sel(input opcode_t op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_INV:  return ALU_INV;
      OP_FLP:  return ALU_FLP;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_ADDI: return ALU_ADDI;
      OP_SUBI: return ALU_SUBI;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bitblaster_controller_if.sv
// Handshake and control bundle between the BitBlaster controller and its
// surroundings (instruction source, register file, ALU, bus steering).
//   master : instruction source side.
//            Drives Run and INST, and observes every control output.
//   slave  : controller side.
//            Consumes Run and INST, and drives every control output.
interface bitblaster_controller_if;
  import bitblaster_pkg::*;

  logic                Run;
  logic [DATA_W-1:0]   INST;
  logic                IRin;
  logic                Extern;
  logic                Ain;
  logic                Gin;
  logic                Gout;
  logic                IMMout;
  logic [DATA_W-1:0]   IMM;
  logic [OPC_W-1:0]    ALUcont;
  logic                ENW;
  logic                ENR0;
  logic                ENR1;
  logic [ADDR_W-1:0]   WRA;
  logic [ADDR_W-1:0]   RDA0;
  logic [ADDR_W-1:0]   RDA1;
  logic                Done;

  modport master (
    output Run, INST,
    input  IRin, Extern, Ain, Gin, Gout, IMMout, IMM, ALUcont,
    input  ENW, ENR0, ENR1, WRA, RDA0, RDA1, Done
  );

  modport slave (
    input  Run, INST,
    output IRin, Extern, Ain, Gin, Gout, IMMout, IMM, ALUcont,
    output ENW, ENR0, ENR1, WRA, RDA0, RDA1, Done
  );
endinterface

// File: rtl/bitblaster_decoder.sv
// Combinational control decoder for the BitBlaster controller.
// It maps the current timestep and the latched instruction fields to the
// control bundle.
//   step_i : current timestep (T0..T3).
//   opc_i  : opcode field of the latched instruction.
//   rx_i   : Rx field of the latched instruction.
//   ry_i   : Ry field of the latched instruction.
//   ctrl_o : control outputs for this timestep.
//            Every field is zero outside the listed steps.
//            ctrl_o.done also tells the sequencer to return to T0.
module bitblaster_decoder
  import bitblaster_pkg::*;
(
  input  tstep_t            step_i,
  input  logic [OPC_W-1:0]  opc_i,
  input  logic [ADDR_W-1:0] rx_i,
  input  logic [ADDR_W-1:0] ry_i,
  output ctrl_t             ctrl_o
);

  opcode_t op;
  assign op = opcode_t'(opc_i);

  always_comb begin
    ctrl_o = '0;
    case (step_i)
      T1: begin
        case (op)
          OP_LOAD: begin
            ctrl_o.extern_sel = 1'b1;
            ctrl_o.enw        = 1'b1;
            ctrl_o.wra        = rx_i;
            ctrl_o.done       = 1'b1;
          end
          OP_COPY: begin
            ctrl_o.enr0 = 1'b1;
            ctrl_o.rda0 = ry_i;
            ctrl_o.enw  = 1'b1;
            ctrl_o.wra  = rx_i;
            ctrl_o.done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SUBI: begin
            ctrl_o.enr0 = 1'b1;
            ctrl_o.rda0 = rx_i;
            ctrl_o.ain  = 1'b1;
          end
          // Unary ops take their operand from Ry and write it back to Rx.
          OP_INV, OP_FLP: begin
            ctrl_o.enr0 = 1'b1;
            ctrl_o.rda0 = ry_i;
            ctrl_o.ain  = 1'b1;
          end
          // Undefined opcodes are single-step NOPs.
          default: ctrl_o.done = 1'b1;
        endcase
      end
      T2: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl_o.enr1    = 1'b1;
            ctrl_o.rda1    = ry_i;
            ctrl_o.gin     = 1'b1;
            ctrl_o.alucont = alu_sel(op);
          end
          // IMM drives the bus instead of register port 1.
          OP_ADDI, OP_SUBI: begin
            ctrl_o.immout  = 1'b1;
            ctrl_o.gin     = 1'b1;
            ctrl_o.alucont = alu_sel(op);
          end
          OP_INV, OP_FLP: begin
            ctrl_o.gin     = 1'b1;
            ctrl_o.alucont = alu_sel(op);
          end
          default: ;
        endcase
      end
      T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SUBI,
          OP_INV, OP_FLP: begin
            ctrl_o.gout = 1'b1;
            ctrl_o.enw  = 1'b1;
            ctrl_o.wra  = rx_i;
            ctrl_o.done = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bitblaster_controller.sv
// Multi-cycle control unit for the 10-bit BitBlaster processor.
// It latches an instruction on Run in T0, then steps through T1..T3.
// The decoder generates the register-file, ALU and bus-steering controls.
//   CLKb  : system clock; all state changes on its rising edge.
//   Clear : synchronous active-high reset; returns to T0 and clears IR.
//   bus   : slave side of bitblaster_controller_if.
//           Inputs are Run and INST.
//           Outputs are IRin, the bus selects, the register-file controls,
//           the ALU strobes, IMM, ALUcont and Done.
module bitblaster_controller
  import bitblaster_pkg::*;
(
  input  logic                    CLKb,
  input  logic                    Clear,
  bitblaster_controller_if.slave  bus
);

  tstep_t            step_q;
  logic [DATA_W-1:0] ir_q;
  ctrl_t             ctrl;

  bitblaster_decoder u_decoder (
    .step_i (step_q),
    .opc_i  (ir_q[OPC_MSB -: OPC_W]),
    .rx_i   (ir_q[RX_LSB +: ADDR_W]),
    .ry_i   (ir_q[RY_LSB +: ADDR_W]),
    .ctrl_o (ctrl)
  );

  // Sequencer.
  // Run is only looked at in T0, so IR stays stable for the whole
  // instruction.
  // Clear wins over everything, which drops an in-flight instruction before
  // its write step.
  always_ff @(posedge CLKb) begin
    if (Clear) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      case (step_q)
        T0: begin
          if (bus.Run) begin
            ir_q   <= bus.INST;
            step_q <= T1;
          end
        end
        T1:      step_q <= ctrl.done ? T0 : T2;
        T2:      step_q <= T3;
        default: step_q <= T0;
      endcase
    end
  end

  // IRin is suppressed while Clear is held so that no capture is advertised.
  assign bus.IRin    = (step_q == T0) && bus.Run && !Clear;
  assign bus.Extern  = ctrl.extern_sel;
  assign bus.Ain     = ctrl.ain;
  assign bus.Gin     = ctrl.gin;
  assign bus.Gout    = ctrl.gout;
  assign bus.IMMout  = ctrl.immout;
  assign bus.IMM     = {{(DATA_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
  assign bus.ALUcont = ctrl.alucont;
  assign bus.ENW     = ctrl.enw;
  assign bus.ENR0    = ctrl.enr0;
  assign bus.ENR1    = ctrl.enr1;
  assign bus.WRA     = ctrl.wra;
  assign bus.RDA0    = ctrl.rda0;
  assign bus.RDA1    = ctrl.rda1;
  assign bus.Done    = ctrl.done;

endmodule

// File: tb/tb_bitblaster_controller.sv
module tb_bitblaster_controller;

  typedef struct packed {
    logic       irin;
    logic       ext;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       immout;
    logic       enw;
    logic       enr0;
    logic       enr1;
    logic       done;
    logic [1:0] wra;
    logic [1:0] rda0;
    logic [1:0] rda1;
    logic [3:0] alu;
  } ov_t;

  logic clk = 1'b0;
  logic Clear;
  int   tests = 0;
  int   fails = 0;
  int   excl_viol = 0;

  always #5 clk = ~clk;

  bitblaster_controller_if bus ();

  bitblaster_controller dut (
    .CLKb  (clk),
    .Clear (Clear),
    .bus   (bus.slave)
  );

  function automatic ov_t obs();
    ov_t o;
    o.irin   = bus.IRin;
    o.ext    = bus.Extern;
    o.ain    = bus.Ain;
    o.gin    = bus.Gin;
    o.gout   = bus.Gout;
    o.immout = bus.IMMout;
    o.enw    = bus.ENW;
    o.enr0   = bus.ENR0;
    o.enr1   = bus.ENR1;
    o.done   = bus.Done;
    o.wra    = bus.WRA;
    o.rda0   = bus.RDA0;
    o.rda1   = bus.RDA1;
    o.alu    = bus.ALUcont;
    return o;
  endfunction

  // Bus sources that must never overlap.
  always @(negedge clk) begin
    if (Clear === 1'b0 &&
        (32'(bus.Extern) + 32'(bus.Gout) + 32'(bus.IMMout) +
         32'(bus.ENR0) + 32'(bus.ENR1)) > 1)
      excl_viol++;
  end

  task automatic test_reset();
    ov_t cur;
    Clear = 1'b1; bus.Run = 1'b1; bus.INST = 10'h3FF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      cur = obs();
      tests++;
      if (cur !== '0) begin
        fails++; $display("FAIL reset_outputs c%0d: got %h expected %h", c, cur, ov_t'('0));
      end
      tests++;
      if (bus.IMM !== 10'h000) begin
        fails++; $display("FAIL reset_imm c%0d: got %h expected %h", c, bus.IMM, 10'h000);
      end
    end
    @(negedge clk);
    Clear = 1'b0; bus.Run = 1'b0; bus.INST = 10'h000;
    #1; cur = obs();
    tests++;
    if (cur !== '0) begin
      fails++; $display("FAIL reset_release: got %h expected %h", cur, ov_t'('0));
    end
    $display("[TB] reset: Clear held 2 cycles with Run=1");
  endtask

  task automatic test_load();
    ov_t cur;
    ov_t e[3];
    logic run[3] = '{1'b1, 1'b0, 1'b0};
    e[0] = '0; e[0].irin = 1'b1;
    e[1] = '0; e[1].ext = 1'b1; e[1].enw = 1'b1; e[1].wra = 2'd2; e[1].done = 1'b1;
    e[2] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.Run = run[c]; bus.INST = 10'h020;
      #1; cur = obs();
      tests++;
      if (cur !== e[c]) begin
        fails++; $display("FAIL load c%0d: got %h expected %h", c, cur, e[c]);
      end
    end
    $display("[TB] LOAD R2 (10'h020)");
  endtask

  task automatic test_add();
    ov_t cur;
    ov_t e[5];
    logic run[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e[0] = '0; e[0].irin = 1'b1;
    e[1] = '0; e[1].enr0 = 1'b1; e[1].rda0 = 2'd1; e[1].ain = 1'b1;
    e[2] = '0; e[2].enr1 = 1'b1; e[2].rda1 = 2'd2; e[2].gin = 1'b1; e[2].alu = 4'b0010;
    e[3] = '0; e[3].gout = 1'b1; e[3].enw = 1'b1; e[3].wra = 2'd1; e[3].done = 1'b1;
    e[4] = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.Run = run[c]; bus.INST = 10'h098;
      #1; cur = obs();
      tests++;
      if (cur !== e[c]) begin
        fails++; $display("FAIL add c%0d: got %h expected %h", c, cur, e[c]);
      end
    end
    $display("[TB] ADD R1,R2 (10'h098)");
  endtask

  task automatic test_addi();
    ov_t cur;
    ov_t e[5];
    logic run[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e[0] = '0; e[0].irin = 1'b1;
    e[1] = '0; e[1].enr0 = 1'b1; e[1].rda0 = 2'd3; e[1].ain = 1'b1;
    e[2] = '0; e[2].immout = 1'b1; e[2].gin = 1'b1; e[2].alu = 4'b1001;
    e[3] = '0; e[3].gout = 1'b1; e[3].enw = 1'b1; e[3].wra = 2'd3; e[3].done = 1'b1;
    e[4] = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.Run = run[c]; bus.INST = 10'h275;
      #1; cur = obs();
      tests++;
      if (cur !== e[c]) begin
        fails++; $display("FAIL addi c%0d: got %h expected %h", c, cur, e[c]);
      end
      if (c == 2) begin
        tests++;
        if (bus.IMM !== 10'h005) begin
          fails++; $display("FAIL addi_imm: got %h expected %h", bus.IMM, 10'h005);
        end
      end
    end
    $display("[TB] ADDI R3,#5 (10'h275)");
  endtask

  task automatic test_unary_nop();
    ov_t cur;
    ov_t e[7];
    logic       run[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [9:0] inst[7] = '{10'h118, 10'h118, 10'h118, 10'h118, 10'h2C0, 10'h2C0, 10'h2C0};
    e[0] = '0; e[0].irin = 1'b1;
    e[1] = '0; e[1].enr0 = 1'b1; e[1].rda0 = 2'd2; e[1].ain = 1'b1;
    e[2] = '0; e[2].gin = 1'b1; e[2].alu = 4'b0100;
    e[3] = '0; e[3].gout = 1'b1; e[3].enw = 1'b1; e[3].wra = 2'd1; e[3].done = 1'b1;
    e[4] = '0; e[4].irin = 1'b1;
    e[5] = '0; e[5].done = 1'b1;
    e[6] = '0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus.Run = run[c]; bus.INST = inst[c];
      #1; cur = obs();
      tests++;
      if (cur !== e[c]) begin
        fails++; $display("FAIL inv_nop c%0d: got %h expected %h", c, cur, e[c]);
      end
    end
    $display("[TB] INV R1,R2 (10'h118) then NOP (10'h2C0)");
  endtask

  task automatic test_back_to_back();
    ov_t cur;
    ov_t e[7];
    logic       run[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [9:0] inst[7] = '{10'h098, 10'h098, 10'h030, 10'h030, 10'h070, 10'h070, 10'h070};
    e[0] = '0; e[0].irin = 1'b1;
    e[1] = '0; e[1].enr0 = 1'b1; e[1].rda0 = 2'd1; e[1].ain = 1'b1;
    e[2] = '0; e[2].enr1 = 1'b1; e[2].rda1 = 2'd2; e[2].gin = 1'b1; e[2].alu = 4'b0010;
    e[3] = '0; e[3].gout = 1'b1; e[3].enw = 1'b1; e[3].wra = 2'd1; e[3].done = 1'b1;
    e[4] = '0; e[4].irin = 1'b1;
    e[5] = '0; e[5].enr0 = 1'b1; e[5].rda0 = 2'd0; e[5].enw = 1'b1; e[5].wra = 2'd3; e[5].done = 1'b1;
    e[6] = '0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus.Run = run[c]; bus.INST = inst[c];
      #1; cur = obs();
      tests++;
      if (cur !== e[c]) begin
        fails++; $display("FAIL back_to_back c%0d: got %h expected %h", c, cur, e[c]);
      end
    end
    $display("[TB] ADD with Run in T2 ignored, then COPY R3,R0 (10'h070) right after Done");
  endtask

  task automatic test_clear_abort();
    ov_t cur;
    ov_t e[6];
    int  enw_seen = 0;
    logic run[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic clr[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    e[0] = '0; e[0].irin = 1'b1;
    e[1] = '0; e[1].enr0 = 1'b1; e[1].rda0 = 2'd2; e[1].ain = 1'b1;
    e[2] = '0; e[2].enr1 = 1'b1; e[2].rda1 = 2'd1; e[2].gin = 1'b1; e[2].alu = 4'b0011;
    e[3] = '0;
    e[4] = '0;
    e[5] = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.Run = run[c]; bus.INST = 10'h0E4; Clear = clr[c];
      #1; cur = obs();
      if (bus.ENW !== 1'b0) enw_seen++;
      tests++;
      if (cur !== e[c]) begin
        fails++; $display("FAIL clear_abort c%0d: got %h expected %h", c, cur, e[c]);
      end
    end
    tests++;
    if (enw_seen !== 0) begin
      fails++; $display("FAIL clear_abort_enw: got %0d write cycles expected 0", enw_seen);
    end
    $display("[TB] SUB R2,R1 (10'h0E4) aborted by Clear in T2");
  endtask

  task automatic test_bus_exclusive();
    tests++;
    if (excl_viol !== 0) begin
      fails++; $display("FAIL bus_exclusive: got %0d violating cycles expected 0", excl_viol);
    end
    $display("[TB] bus exclusivity over whole run");
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_addi();
    test_unary_nop();
    test_back_to_back();
    test_clear_abort();
    test_bus_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitblaster_controller.md
Name: bitblaster_controller

Overview:
- Multi-cycle control unit for the 10-bit BitBlaster processor.
- Sits directly upstream of the register file: latches an instruction, then sequences register-file read/write addresses and enables, ALU operand/result strobes, and external-data selection over timesteps T0–T3.
- Drives ENW/ENR0/ENR1/WRA/RDA0/RDA1 of the register file; steers the shared 10-bit bus through Extern/Gout/IMMout.

Parameters:
- DATA_W, 10, instruction and bus width.
- ADDR_W, 2, register address width.
- OPC_W, 4, opcode width (INST[9:6]).

Ports:
- CLKb  input  1  debounced system clock; all state changes on posedge.
- Clear  input  1  synchronous, active-high reset.
- Run  input  1  start pulse; accepted only in T0.
- INST  input  10  instruction word: [9:6] opcode, [5:4] Rx, [3:2] Ry, [3:0] imm.
- IRin  output  1  high in the cycle INST is captured.
- Extern  output  1  bus driven by external data.
- Ain  output  1  load ALU A register from bus.
- Gin  output  1  load ALU G register.
- Gout  output  1  bus driven by G.
- IMMout  output  1  bus driven by IMM.
- IMM  output  10  zero-extended IR[3:0].
- ALUcont  output  4  ALU operation select.
- ENW  output  1  register-file write enable.
- ENR0  output  1  register-file read enable, port 0.
- ENR1  output  1  register-file read enable, port 1.
- WRA  output  2  write address.
- RDA0  output  2  read address, port 0.
- RDA1  output  2  read address, port 1.
- Done  output  1  one-cycle pulse marking the instruction's final step.

Behaviour:
- State: T0 (idle), T1, T2, T3; IR[9:0] register.
- All outputs are combinational from state and IR (Moore).
- Outside listed steps, every output is 0 and every address is 2'b00.
- Clear at posedge: state <= T0, IR <= 0. All outputs are then 0, including IMM and ALUcont.
- Clear has priority over Run and over any in-flight step. An aborted instruction performs no further write.
- T0: IRin = Run. If Run, IR <= INST and go to T1; otherwise stay in T0.
- T0 only: Run is ignored in T1–T3, and IR is not disturbed.
- Opcodes and ALUcont:
  - LOAD 0000, COPY 0001.
  - ADD 0010, SUB 0011, INV 0100, FLP 0101 (two's-complement negate).
  - AND 0110, OR 0111, XOR 1000.
  - ADDI 1001, SUBI 1010.
  - ALUcont equals the opcode during T2. It is 0 elsewhere.
- LOAD, T1: Extern=1, ENW=1, WRA=Rx, Done=1, then go to T0. Latency 2 cycles from Run.
- COPY, T1: ENR0=1, RDA0=Ry, ENW=1, WRA=Rx, Done=1, then go to T0. Rx==Ry is legal; the register rewrites its own value.
- Binary ops (ADD, SUB, AND, OR, XOR):
  - T1: ENR0=1, RDA0=Rx, Ain=1.
  - T2: ENR1=1, RDA1=Ry, Gin=1.
  - T3: Gout=1, ENW=1, WRA=Rx, Done=1, then go to T0.
- Immediate ops (ADDI, SUBI): same as binary ops, except T2 has IMMout=1 and ENR1=0.
- Unary ops (INV, FLP):
  - T1: ENR0=1, RDA0=Ry, Ain=1.
  - T2: Gin=1, no read.
  - T3: write Rx with Done.
- Opcodes 1011–1111: NOP. T1 asserts only Done, then go to T0.
- Back-to-back: Run is accepted in the T0 cycle immediately following Done. Minimum instruction period is 2 cycles (LOAD, COPY, NOP) or 4 cycles (all others).
- Bus exclusivity invariant: at most one of Extern, Gout, IMMout, ENR0 and ENR1 asserts in any cycle.

Decomposition:
- bitblaster_pkg holds:
  - opcode_t enum (4-bit, values above).
  - tstep_t enum T0..T3.
  - Field-slice constants OPC_MSB=9, RX_LSB=4, RY_LSB=2.
  - ALU op localparams.
- One natural sub-module: bitblaster_decoder. It is combinational and maps (tstep_t, IR) to the control-signal bundle. The top keeps the state register and IR.

Test Plan:
- Clear held 2 cycles with Run=1, INST=10'h3FF → state stays T0; IR=0; all outputs 0; no IRin.
- Run with INST=0000_10_0000 (LOAD R2) → T1: Extern=1, ENW=1, WRA=2, Done=1; next cycle T0.
- INST=0010_01_10_00 (ADD R1,R2) → T1: ENR0, RDA0=1, Ain. T2: ENR1, RDA1=2, Gin, ALUcont=0010. T3: Gout, ENW, WRA=1, Done.
- INST=1001_11_0101 (ADDI R3,#5) → T2: IMMout=1, IMM=10'h005, ENR1=0. T3: WRA=3.
- Run pulsed in T2 of an ADD with a different INST → IR unchanged, completes as ADD. Second Run in the T0 cycle after Done → accepted.
- Clear asserted in T2 of a SUB → next cycle T0; ENW never asserted for that instruction; bus-exclusivity assertion holds throughout.
